// File: rtl/sseg_display_driver_if.sv
// Bundles the value/mode inputs and the display outputs of sseg_display_driver.
// The source side (ALU / bench) uses master, the driver uses slave.
interface sseg_display_driver_if #(
    parameter int WIDTH    = 16,
    parameter int N_DIGITS = 8
) ();
    logic [WIDTH-1:0]    value;
    logic                dec;
    logic                busy;
    logic                done;
    logic [N_DIGITS-1:0] anodes;
    logic [6:0]          segments;

    modport master (
        output value,
        output dec,
        input  busy,
        input  done,
        input  anodes,
        input  segments
    );

    modport slave (
        input  value,
        input  dec,
        output busy,
        output done,
        output anodes,
        output segments
    );
endinterface

// File: rtl/sseg_display_driver.sv
// Converts an unsigned value to hex or BCD digits (sequential double-dabble) and
// scans them onto a multiplexed common-anode 7-segment bank with leading-zero blanking.
module sseg_display_driver #(
    parameter int WIDTH       = 16,
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    sseg_display_driver_if.slave  bus
);
    // Decimal digits of 2^WIDTH-1: floor(WIDTH*log10(2))+1, log10(2) ~ 1233/4096.
    localparam int BCD_DIGITS = (WIDTH * 1233) / 4096 + 1;
    localparam int DISP_W     = 4 * N_DIGITS;
    localparam int CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int REF_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    generate
        if ((N_DIGITS < BCD_DIGITS) || (DISP_W < WIDTH)) begin : g_bad_digits
            $error("sseg_display_driver: N_DIGITS too small for WIDTH");
        end
        if (REFRESH_DIV < 2) begin : g_bad_refresh
            $error("sseg_display_driver: REFRESH_DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    function automatic logic [DISP_W-1:0] dabble_adjust(input logic [DISP_W-1:0] b);
        logic [DISP_W-1:0] r;
        r = b;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t              state_r,     state_s;
    logic [WIDTH-1:0]    cap_value_r, cap_value_s;
    logic                cap_dec_r,   cap_dec_s;
    logic [WIDTH-1:0]    shift_r,     shift_s;
    logic [DISP_W-1:0]   bcd_r,       bcd_s;
    logic [CNT_W-1:0]    bit_cnt_r,   bit_cnt_s;
    logic [DISP_W-1:0]   disp_r,      disp_s;
    logic                busy_r,      busy_s;
    logic                done_r,      done_s;
    logic [DISP_W-1:0]   adj_s;

    logic [REF_W-1:0]    refresh_r;
    logic [IDX_W-1:0]    idx_r;
    logic [N_DIGITS-1:0] anodes_r;
    logic [6:0]          segments_r;
    logic [DISP_W-1:0]   upper_s;
    logic [3:0]          digit_s;
    logic                blank_s;

    // Add-3 correction of every BCD digit ahead of the next shift.
    always_comb begin
        adj_s = dabble_adjust(bcd_r);
    end

    // Conversion FSM: next state and next datapath values.
    always_comb begin
        state_s     = state_r;
        cap_value_s = cap_value_r;
        cap_dec_s   = cap_dec_r;
        shift_s     = shift_r;
        bcd_s       = bcd_r;
        bit_cnt_s   = bit_cnt_r;
        disp_s      = disp_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ({bus.value, bus.dec} != {cap_value_r, cap_dec_r}) begin
                    cap_value_s = bus.value;
                    cap_dec_s   = bus.dec;
                    shift_s     = bus.value;
                    bcd_s       = {DISP_W{1'b0}};
                    bit_cnt_s   = {CNT_W{1'b0}};
                    busy_s      = 1'b1;
                    state_s     = ST_CONV;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (!cap_dec_r) begin
                    bcd_s   = DISP_W'(cap_value_r);
                    state_s = ST_COMMIT;
                end else begin
                    {bcd_s, shift_s} = {adj_s, shift_r} << 1;
                    if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_s = ST_COMMIT;
                    end else begin
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                        state_s   = ST_CONV;
                    end
                end
            end
            ST_COMMIT: begin
                // Only complete results ever reach the display register.
                disp_s  = bcd_r;
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Conversion FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cap_value_r <= {WIDTH{1'b0}};
            cap_dec_r   <= 1'b0;
            shift_r     <= {WIDTH{1'b0}};
            bcd_r       <= {DISP_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            disp_r      <= {DISP_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cap_value_r <= cap_value_s;
            cap_dec_r   <= cap_dec_s;
            shift_r     <= shift_s;
            bcd_r       <= bcd_s;
            bit_cnt_r   <= bit_cnt_s;
            disp_r      <= disp_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Digit under the scan pointer; blank when it and everything above it is zero.
    always_comb begin
        upper_s = disp_r >> {idx_r, 2'b00};
        digit_s = upper_s[3:0];
        blank_s = (idx_r != {IDX_W{1'b0}}) && (upper_s == {DISP_W{1'b0}});
    end

    // Refresh divider, scan pointer and registered pin drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_r  <= {REF_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            anodes_r   <= ~N_DIGITS'(1);
            segments_r <= 7'b1000000;
        end else begin
            if (refresh_r == REF_W'(REFRESH_DIV - 1)) begin
                refresh_r <= {REF_W{1'b0}};
                idx_r     <= (idx_r == IDX_W'(N_DIGITS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end else begin
                refresh_r <= refresh_r + REF_W'(1);
                idx_r     <= idx_r;
            end
            anodes_r   <= ~(N_DIGITS'(1) << idx_r);
            segments_r <= blank_s ? 7'h7F : glyph(digit_s);
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.anodes   = anodes_r;
    assign bus.segments = segments_r;

endmodule
